// File: rtl/mau_pkg.sv
// Shared types for the memory access unit: FSM states, access size codes and
// response error codes.
package mau_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_BUS      = 2'd1,
    ERR_MISALIGN = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_e;

endpackage

// File: rtl/mau_align.sv
// Combinational lane steering for the memory access unit: misalignment
// detection, byte enables, store data shifting and load extraction/extension.
module mau_align
  import mau_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] offset_i,
  input  size_e                     size_i,
  input  logic                      unsigned_i,
  input  logic [XLEN-1:0]           wdata_i,
  input  logic [XLEN-1:0]           rdata_lo_i,
  input  logic [XLEN-1:0]           rdata_hi_i,
  output logic                      misalign_o,
  output logic                      oversize_o,
  output logic [XLEN/8-1:0]         be0_o,
  output logic [XLEN/8-1:0]         be1_o,
  output logic [XLEN-1:0]           wdata0_o,
  output logic [XLEN-1:0]           wdata1_o,
  output logic [XLEN-1:0]           rdata_o
);
  localparam int NB = XLEN / 8;

  logic [3:0]        nbytes;
  logic [6:0]        nbits;
  logic [2*NB-1:0]   be_wide;
  logic [2*XLEN-1:0] wd_wide;
  logic [XLEN-1:0]   rd_shift;
  logic [XLEN-1:0]   ext_mask;
  logic              sign_bit;

  assign nbytes     = 4'd1 << size_i;
  assign nbits      = {nbytes, 3'b000};
  assign misalign_o = (int'(offset_i) + int'(nbytes)) > NB;
  assign oversize_o = int'(nbytes) > NB;

  // Both halves of the double-width views are the two bus beats.
  assign be_wide  = (2*NB)'(8'hFF >> (4'd8 - nbytes)) << offset_i;
  assign be0_o    = be_wide[NB-1:0];
  assign be1_o    = be_wide[2*NB-1:NB];
  assign wd_wide  = {{XLEN{1'b0}}, wdata_i} << {offset_i, 3'b000};
  assign wdata0_o = wd_wide[XLEN-1:0];
  assign wdata1_o = wd_wide[2*XLEN-1:XLEN];
  assign rd_shift = XLEN'({rdata_hi_i, rdata_lo_i} >> {offset_i, 3'b000});

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    ext_mask = '0;
    sign_bit = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      if (i >= int'(nbits))          ext_mask[i] = 1'b1;
      else if (i == int'(nbits) - 1) sign_bit    = rd_shift[i];
    end
    rdata_o = rd_shift & ~ext_mask;
    if (!unsigned_i && sign_bit) rdata_o = rdata_o | ext_mask;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a simple strobed data bus; splits
// misaligned accesses into two beats and reports bus, alignment and timeout errors.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int AW             = 32,
  parameter int TIMEOUT        = 255,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic              CLK,
  input  logic              RESN,
  input  logic              HLT,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [1:0]        REQ_SIZE,
  input  logic              REQ_UNSIGNED,
  input  logic [AW-1:0]     REQ_ADDR,
  input  logic [XLEN-1:0]   REQ_WDATA,
  input  logic [4:0]        REQ_RD,
  output logic              RSP_VALID,
  output logic [XLEN-1:0]   RSP_DATA,
  output logic [4:0]        RSP_RD,
  output logic [1:0]        RSP_ERR,
  output logic [AW-1:0]     DADDR,
  output logic [XLEN-1:0]   DATAO,
  output logic [XLEN/8-1:0] DBE,
  output logic              DRD,
  output logic              DWR,
  output logic              DAS,
  input  logic [XLEN-1:0]   DATAI,
  input  logic              DACK,
  input  logic              BERR
);
  localparam int NB  = XLEN / 8;
  localparam int OW  = $clog2(NB);
  localparam int WCW = $clog2(TIMEOUT + 1) + 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  err_e            err_q, err_d;
  size_e           size_q, sel_size;
  logic            run_q, we_q, uns_q;
  logic [AW-1:0]   addr_q, beat_base;
  logic [XLEN-1:0] wdata_q, lo_q, rsp_data_q, rsp_data_d;
  logic [4:0]      rd_q;
  logic [WCW-1:0]  wait_q, wait_d;
  logic [OW-1:0]   sel_off;
  logic            accept, in_beat, timeout_hit, enter_resp, misalign, oversize;
  logic [NB-1:0]   be0, be1;
  logic [XLEN-1:0] wd0, wd1, rd_lo, rd_hi, load_data;

  // The aligner sees the live request while idle (accept decision) and the
  // latched request once the access is in flight.
  assign sel_off  = (state_q == ST_IDLE) ? REQ_ADDR[OW-1:0] : addr_q[OW-1:0];
  assign sel_size = (state_q == ST_IDLE) ? size_e'(REQ_SIZE) : size_q;
  assign rd_lo    = (state_q == ST_BEAT1) ? lo_q : DATAI;
  assign rd_hi    = (state_q == ST_BEAT1) ? DATAI : '0;

  mau_align #(.XLEN(XLEN)) u_align (
    .offset_i   (sel_off),
    .size_i     (sel_size),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .rdata_lo_i (rd_lo),
    .rdata_hi_i (rd_hi),
    .misalign_o (misalign),
    .oversize_o (oversize),
    .be0_o      (be0),
    .be1_o      (be1),
    .wdata0_o   (wd0),
    .wdata1_o   (wd1),
    .rdata_o    (load_data)
  );

  assign REQ_READY   = run_q && (state_q == ST_IDLE) && !HLT;
  assign accept      = REQ_VALID && REQ_READY;
  assign in_beat     = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);
  assign timeout_hit = (TIMEOUT != 0) && in_beat && !DACK && !BERR && (wait_q == WAIT_LAST);

  always_ff @(posedge CLK or negedge RESN) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!RESN) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Oversize (dword on a 32-bit bus) cannot be split into two beats, so it
  // always reports a misalignment.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        if (oversize || (misalign && MISALIGN_SPLIT == 0)) begin
          state_d = ST_RESP;
          err_d   = ERR_MISALIGN;
        end else begin
          state_d = ST_BEAT0;
        end
      end
      ST_BEAT0, ST_BEAT1: begin
        if (BERR) begin
          state_d = ST_RESP;
          err_d   = ERR_BUS;
        end else if (DACK) begin
          state_d = (state_q == ST_BEAT0 && misalign) ? ST_BEAT1 : ST_RESP;
          err_d   = ERR_OK;
        end else if (timeout_hit) begin
          state_d = ST_RESP;
          err_d   = ERR_TIMEOUT;
        end
      end
      ST_RESP: if (!HLT) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign rsp_data_d = (err_d == ERR_OK && !we_q) ? load_data : '0;
  assign wait_d     = (in_beat && state_d == state_q) ? wait_q + 1'b1 : '0;

  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      run_q      <= 1'b0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= SZ_BYTE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      lo_q       <= '0;
      wait_q     <= '0;
      rsp_data_q <= '0;
      err_q      <= ERR_OK;
    end else begin
      run_q  <= 1'b1;
      wait_q <= wait_d;
      if (accept) begin
        we_q    <= REQ_WE;
        uns_q   <= REQ_UNSIGNED;
        size_q  <= size_e'(REQ_SIZE);
        addr_q  <= REQ_ADDR;
        wdata_q <= REQ_WDATA;
        rd_q    <= REQ_RD;
      end
      if (state_q == ST_BEAT0 && DACK) lo_q <= DATAI;
      if (enter_resp) begin
        rsp_data_q <= rsp_data_d;
        err_q      <= err_d;
      end
    end
  end

  assign beat_base = {addr_q[AW-1:OW], {OW{1'b0}}};

  always_comb begin
    DAS   = 1'b0;
    DRD   = 1'b0;
    DWR   = 1'b0;
    DADDR = '0;
    DBE   = '0;
    DATAO = '0;
    if (in_beat) begin
      DAS   = 1'b1;
      DRD   = !we_q;
      DWR   = we_q;
      DADDR = beat_base;
      DBE   = be0;
      DATAO = wd0;
      if (state_q == ST_BEAT1) begin
        DADDR = beat_base + AW'(NB);
        DBE   = be1;
        DATAO = wd1;
      end
    end
  end

  assign RSP_VALID = (state_q == ST_RESP);
  assign RSP_DATA  = rsp_data_q;
  assign RSP_RD    = rd_q;
  assign RSP_ERR   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table of zero-wait accesses plus
// hand sequences for wait states, timeout, stall, no-split mode and reset.
module tb_mem_access_unit;
  localparam int XLEN = 32;
  localparam int AW   = 32;

  logic            clk = 1'b0, resn = 1'b1, hlt = 1'b0;
  logic            req_valid = 1'b0, req_valid_ns = 1'b0;
  logic            req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]      req_size = 2'd0;
  logic [AW-1:0]   req_addr = '0;
  logic [XLEN-1:0] req_wdata = '0, datai = '0;
  logic [4:0]      req_rd = '0;
  logic            dack = 1'b0, berr = 1'b0;

  logic req_ready, rsp_valid, drd, dwr, das;
  logic [XLEN-1:0] rsp_data, datao;
  logic [4:0] rsp_rd;
  logic [1:0] rsp_err;
  logic [AW-1:0] daddr;
  logic [3:0] dbe;

  logic req_ready_ns, rsp_valid_ns, drd_ns, dwr_ns, das_ns;
  logic [XLEN-1:0] rsp_data_ns, datao_ns;
  logic [4:0] rsp_rd_ns;
  logic [1:0] rsp_err_ns;
  logic [AW-1:0] daddr_ns;
  logic [3:0] dbe_ns;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(XLEN), .AW(AW), .TIMEOUT(4), .MISALIGN_SPLIT(1)) u_dut (
    .CLK(clk), .RESN(resn), .HLT(hlt),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we), .REQ_SIZE(req_size),
    .REQ_UNSIGNED(req_unsigned), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .REQ_RD(req_rd),
    .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data), .RSP_RD(rsp_rd), .RSP_ERR(rsp_err),
    .DADDR(daddr), .DATAO(datao), .DBE(dbe), .DRD(drd), .DWR(dwr), .DAS(das),
    .DATAI(datai), .DACK(dack), .BERR(berr)
  );

  mem_access_unit #(.XLEN(XLEN), .AW(AW), .TIMEOUT(4), .MISALIGN_SPLIT(0)) u_dut_ns (
    .CLK(clk), .RESN(resn), .HLT(hlt),
    .REQ_VALID(req_valid_ns), .REQ_READY(req_ready_ns), .REQ_WE(req_we), .REQ_SIZE(req_size),
    .REQ_UNSIGNED(req_unsigned), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .REQ_RD(req_rd),
    .RSP_VALID(rsp_valid_ns), .RSP_DATA(rsp_data_ns), .RSP_RD(rsp_rd_ns), .RSP_ERR(rsp_err_ns),
    .DADDR(daddr_ns), .DATAO(datao_ns), .DBE(dbe_ns), .DRD(drd_ns), .DWR(dwr_ns), .DAS(das_ns),
    .DATAI(datai), .DACK(dack), .BERR(berr)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        berr0;
    int          beats;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] o0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] o1;
    logic [31:0] data;
    logic [1:0]  err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    issue(v.we, v.size, v.uns, v.addr, v.wdata, v.rd);
    req_valid = 1'b1;
    #1;
    check($sformatf("%s.ready", v.name), req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    for (int b = 0; b < v.beats; b++) begin
      check($sformatf("%s.das%0d", v.name, b), das, 1);
      check($sformatf("%s.rdwr%0d", v.name, b), {drd, dwr}, v.we ? 2'b01 : 2'b10);
      check($sformatf("%s.daddr%0d", v.name, b), daddr, (b == 0) ? v.a0 : v.a1);
      check($sformatf("%s.dbe%0d", v.name, b), dbe, (b == 0) ? v.be0 : v.be1);
      check($sformatf("%s.datao%0d", v.name, b), datao, (b == 0) ? v.o0 : v.o1);
      dack  = 1'b1;
      berr  = (b == 0) && v.berr0;
      datai = (b == 0) ? v.d0 : v.d1;
      @(negedge clk);
      dack = 1'b0; berr = 1'b0; datai = '0;
    end
    check($sformatf("%s.rsp_valid", v.name), rsp_valid, 1);
    check($sformatf("%s.das_off", v.name), das, 0);
    check($sformatf("%s.rsp_data", v.name), rsp_data, v.data);
    check($sformatf("%s.rsp_err", v.name), rsp_err, v.err);
    check($sformatf("%s.rsp_rd", v.name), rsp_rd, v.rd);
    @(negedge clk);
    check($sformatf("%s.idle", v.name), rsp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    //          name            we    sz     u     addr          wdata         rd     d0            d1            be   bt a0            be0    o0            a1            be1    o1            data          err
    vecs[0]  = '{"ld_w_100",    1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,        5'd1,  32'hDEAD_BEEF, 32'h0,       1'b0, 1, 32'h0000_0100, 4'hF, 32'h0,        32'h0,        4'h0, 32'h0,        32'hDEAD_BEEF, 2'd0};
    vecs[1]  = '{"ld_b_103s",   1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0,        5'd2,  32'h8000_0000, 32'h0,       1'b0, 1, 32'h0000_0100, 4'h8, 32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFF_FF80, 2'd0};
    vecs[2]  = '{"ld_b_103u",   1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0,        5'd3,  32'h8000_0000, 32'h0,       1'b0, 1, 32'h0000_0100, 4'h8, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0000_0080, 2'd0};
    vecs[3]  = '{"st_w_102",    1'b1, 2'd2, 1'b0, 32'h0000_0102, 32'h1122_3344, 5'd4, 32'h0,        32'h0,        1'b0, 2, 32'h0000_0100, 4'hC, 32'h3344_0000, 32'h0000_0104, 4'h3, 32'h0000_1122, 32'h0,        2'd0};
    vecs[4]  = '{"ld_h_102s",   1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0,        5'd5,  32'h9ABC_0000, 32'h0,       1'b0, 1, 32'h0000_0100, 4'hC, 32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFF_9ABC, 2'd0};
    vecs[5]  = '{"ld_h_103u",   1'b0, 2'd1, 1'b1, 32'h0000_0103, 32'h0,        5'd6,  32'hAB00_0000, 32'h0000_00CD, 1'b0, 2, 32'h0000_0100, 4'h8, 32'h0,      32'h0000_0104, 4'h1, 32'h0,        32'h0000_CDAB, 2'd0};
    vecs[6]  = '{"ld_w_201s",   1'b0, 2'd2, 1'b0, 32'h0000_0201, 32'h0,        5'd7,  32'h3322_1100, 32'h7766_5544, 1'b0, 2, 32'h0000_0200, 4'hE, 32'h0,      32'h0000_0204, 4'h1, 32'h0,        32'h4433_2211, 2'd0};
    vecs[7]  = '{"st_b_101",    1'b1, 2'd0, 1'b0, 32'h0000_0101, 32'h1234_56A5, 5'd8, 32'h0,        32'h0,        1'b0, 1, 32'h0000_0100, 4'h2, 32'h3456_A500, 32'h0,        4'h0, 32'h0,        32'h0,        2'd0};
    vecs[8]  = '{"st_h_103",    1'b1, 2'd1, 1'b0, 32'h0000_0103, 32'h0000_BEEF, 5'd9, 32'h0,        32'h0,        1'b0, 2, 32'h0000_0100, 4'h8, 32'hEF00_0000, 32'h0000_0104, 4'h1, 32'h0000_00BE, 32'h0,        2'd0};
    vecs[9]  = '{"ld_w_102_be", 1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0,        5'd10, 32'hFFFF_FFFF, 32'h0,       1'b1, 1, 32'h0000_0100, 4'hC, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        2'd1};
    vecs[10] = '{"ld_b_100s",   1'b0, 2'd0, 1'b0, 32'h0000_0100, 32'h0,        5'd11, 32'h1234_567F, 32'h0,       1'b0, 1, 32'h0000_0100, 4'h1, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0000_007F, 2'd0};
    vecs[11] = '{"ld_h_100s",   1'b0, 2'd1, 1'b0, 32'h0000_0100, 32'h0,        5'd12, 32'h0000_8001, 32'h0,       1'b0, 1, 32'h0000_0100, 4'h3, 32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFF_8001, 2'd0};

    // Reset state.
    #1 resn = 1'b0;
    #10;
    check("rst.ready", req_ready, 0);
    check("rst.das", das, 0);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.rsp_err", rsp_err, 0);
    @(negedge clk);
    resn = 1'b1;
    @(negedge clk);
    check("rst.ready_after", req_ready, 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Word load with two wait states: response 4 cycles after accept.
    @(negedge clk);
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd20);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("lat.valid_c%0d", k), rsp_valid, 0);
      check($sformatf("lat.das_c%0d", k), das, 1);
      if (k == 3) begin dack = 1'b1; datai = 32'hDEAD_BEEF; end
      @(negedge clk);
    end
    dack = 1'b0; datai = '0;
    check("lat.valid_c4", rsp_valid, 1);
    check("lat.data", rsp_data, 32'hDEAD_BEEF);
    check("lat.err", rsp_err, 0);
    @(negedge clk);

    // Timeout: DACK never comes, strobes drop after 4 wait cycles.
    issue(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 5'd21);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("to.das_c%0d", k), das, 1);
      @(negedge clk);
    end
    check("to.das_drop", das, 0);
    check("to.rsp_valid", rsp_valid, 1);
    check("to.err", rsp_err, 3);
    check("to.data", rsp_data, 0);
    @(negedge clk);

    // Stall during the response holds it stable.
    issue(1'b0, 2'd2, 1'b0, 32'h108, 32'h0, 5'd22);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    dack = 1'b1; datai = 32'hCAFE_F00D;
    @(negedge clk);
    dack = 1'b0; datai = '0;
    check("hlt.valid0", rsp_valid, 1);
    hlt = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("hlt.valid%0d", k), rsp_valid, 1);
      check($sformatf("hlt.data%0d", k), rsp_data, 32'hCAFE_F00D);
      check($sformatf("hlt.rd%0d", k), rsp_rd, 22);
      check($sformatf("hlt.ready%0d", k), req_ready, 0);
    end
    hlt = 1'b0;
    @(negedge clk);
    check("hlt.released", rsp_valid, 0);
    check("hlt.ready_back", req_ready, 1);

    // No-split instance: misaligned store is rejected without bus activity.
    issue(1'b1, 2'd2, 1'b0, 32'h102, 32'h1122_3344, 5'd23);
    req_valid_ns = 1'b1;
    #1;
    check("ns.ready", req_ready_ns, 1);
    @(negedge clk);
    req_valid_ns = 1'b0;
    check("ns.das", das_ns, 0);
    check("ns.rsp_valid", rsp_valid_ns, 1);
    check("ns.err", rsp_err_ns, 2);
    check("ns.data", rsp_data_ns, 0);
    check("ns.rd", rsp_rd_ns, 23);
    @(negedge clk);
    check("ns.idle", rsp_valid_ns, 0);

    // Reset in the middle of a beat.
    issue(1'b0, 2'd2, 1'b0, 32'h10C, 32'h0, 5'd24);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rmid.das_before", das, 1);
    #2 resn = 1'b0;
    #1;
    check("rmid.das", das, 0);
    check("rmid.drd", drd, 0);
    check("rmid.daddr", daddr, 0);
    check("rmid.ready", req_ready, 0);
    @(negedge clk);
    resn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("rmid.no_rsp%0d", k), rsp_valid, 0);
      if (k == 1) check("rmid.ready_after", req_ready, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
